orientation_histogram: RTL and testbench
========================================

// Module: orientation_histogram
// PURPOSE
// Downstream consumer of binary_divider. Takes each gradient ratio quotient = |Gy|/|Gx|
// with the gradient signs and magnitude, and maps it to one of 8 unsigned orientation
// bins (22.5 deg each, 0..180 deg). Accumulates magnitude per bin over a cell of CELL_N
// samples, then streams the 8 bin totals to the descriptor stage with valid/ready.
// PARAMETERS
// CELL_N  64  samples per cell (>=1)
// MAG_W   16  gradient magnitude width
// ACC_W   24  bin accumulator width (saturating)
// T1      7   Q4.4 threshold tan(22.5)
// T2      16  Q4.4 threshold tan(45)
// T3      39  Q4.4 threshold tan(67.5)
// PORTS
// clk          in   1      clock, rising edge
// reset        in   1      synchronous, active-low reset
// in_valid     in   1      quotient/sign/mag valid (driven by divider ready)
// quotient     in   8      unsigned Q4.4 |Gy|/|Gx|, saturated at 8'hFF
// sign_x       in   1      1 = Gx negative
// sign_y       in   1      1 = Gy negative
// gx_zero      in   1      Gx == 0; quotient is ignored
// mag          in   MAG_W  gradient magnitude
// in_ready     out  1      1 = sample will be accepted this cycle
// hist_valid   out  1      bin total on hist_data is valid
// hist_ready   in   1      descriptor stage accepts bin
// hist_bin     out  3      bin index 0..7
// hist_data    out  ACC_W  bin total
// overrun      out  1      sticky: in_valid seen while in_ready=0
// BEHAVIOUR
// - Interface: one clock clk; reset synchronous, active-low.
// - Reset (reset=0 at edge): state=ACCUM, all 8 bins=0, sample count=0, pipeline empty,
//   hist_valid=0, hist_bin=0, hist_data=0, overrun=0.
// - in_ready = (state==ACCUM). Accept = in_valid & in_ready.
// - Quantise: sub = q<T1 ? 0 : q<T2 ? 1 : q<T3 ? 2 : 3.
//   bin = (sign_x^sign_y) ? 7-sub : sub. gx_zero=1 forces bin=4, regardless of quotient and signs.
// - Pipeline: edge k registers {bin,mag} (stage 1). Edge k+1 adds mag to bins[bin], saturating
//   at 2^ACC_W-1. Back-to-back samples to the same bin accumulate correctly; no hazard is allowed.
// - ACCUM: count increments on each accept. The edge that accepts sample CELL_N resets count to 0
//   and moves to FLUSH.
// - FLUSH: waits until stage 1 and stage 2 are empty (2 cycles), then moves to DUMP with idx=0.
// - DUMP: hist_valid=1, hist_bin=idx, hist_data=bins[idx], all registered. Data holds while
//   hist_ready=0. On valid&ready, bins[idx] is cleared and idx increments. The transfer of idx 7
//   drops hist_valid and returns to ACCUM next cycle.
// - in_valid while not in ACCUM: sample dropped, overrun set (cleared only by reset).
// - Reset mid-cell or mid-DUMP: discards partial totals; no further hist beats are issued.
// TESTING
// 1 Reset: hold reset=0 2 cycles -> hist_valid=0, overrun=0, in_ready=1.
// 2 CELL_N=4; 4 samples q=194, signs 0/0, mag=100 -> one DUMP: bin3=400, all other bins=0, order 0..7.
// 3 Boundaries: q=6,7,15,16,38,39 with signs 0/0 -> bins 0,1,1,2,2,3.
//   q=6 with sign_x=1 -> bin 7. gx_zero=1 -> bin 4.
// 4 Saturation: ACC_W=8; 4 samples mag=100, same bin -> hist_data=255.
// 5 Backpressure: hist_ready low 3 cycles on bin 2 -> hist_data stable. in_valid during DUMP
//   -> overrun=1, and the next cell's totals exclude the dropped sample.
// 6 Reset asserted at bin 4 of DUMP -> hist_valid=0 next cycle; next cell starts from all-zero bins.

Source files
------------

// File: rtl/orientation_histogram.sv
// Maps gradient ratio quotients to 8 unsigned orientation bins. Accumulates magnitude per
// bin over a cell of CELL_N samples, then streams the 8 bin totals out with valid/ready.
module orientation_histogram #(
  parameter int CELL_N = 64,
  parameter int MAG_W  = 16,
  parameter int ACC_W  = 24,
  parameter int T1     = 7,
  parameter int T2     = 16,
  parameter int T3     = 39
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       quotient,
  input  logic             sign_x,
  input  logic             sign_y,
  input  logic             gx_zero,
  input  logic [MAG_W-1:0] mag,
  output logic             in_ready,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [2:0]       hist_bin,
  output logic [ACC_W-1:0] hist_data,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DUMP  = 2'd2
  } state_e;

  localparam int CW    = $clog2(CELL_N + 1);
  localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_e             state_q;
  logic               in_ready_q;
  logic [CW-1:0]      count_q;
  logic               s1_valid_q;
  logic [2:0]         s1_bin_q;
  logic [MAG_W-1:0]   s1_mag_q;
  logic               s2_valid_q;
  logic [ACC_W-1:0]   bins_q [8];
  logic               hist_valid_q;
  logic [2:0]         hist_bin_q;
  logic [ACC_W-1:0]   hist_data_q;
  logic               overrun_q;

  logic               accept_d;
  logic [SUM_W-1:0]   acc_sum_d;
  logic [ACC_W-1:0]   acc_next_d;

  // Unsigned orientation: mirrored sub-sector when exactly one gradient component is negative.
  function automatic logic [2:0] quantise(input logic [7:0] q, input logic sx,
                                          input logic sy, input logic gz);
    logic [1:0] sub;
    if (q < 8'(T1)) begin
      sub = 2'd0;
    end else if (q < 8'(T2)) begin
      sub = 2'd1;
    end else if (q < 8'(T3)) begin
      sub = 2'd2;
    end else begin
      sub = 2'd3;
    end
    if (gz) begin
      return 3'd4;
    end else if (sx ^ sy) begin
      return 3'd7 - {1'b0, sub};
    end else begin
      return {1'b0, sub};
    end
  endfunction

  assign accept_d   = in_valid & in_ready_q;
  assign in_ready   = in_ready_q;
  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_data  = hist_data_q;
  assign overrun    = overrun_q;

  // Saturating read-modify-write value for the bin addressed by stage 1.
  always_comb begin
    acc_sum_d = {{(SUM_W-ACC_W){1'b0}}, bins_q[s1_bin_q]} + {{(SUM_W-MAG_W){1'b0}}, s1_mag_q};
    if (acc_sum_d > ACC_MAX) begin
      acc_next_d = {ACC_W{1'b1}};
    end else begin
      acc_next_d = acc_sum_d[ACC_W-1:0];
    end
  end

  // Control FSM, sample pipeline, bin storage and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_ACCUM;
      in_ready_q   <= 1'b1;
      count_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= 3'd0;
      s1_mag_q     <= '0;
      s2_valid_q   <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 3'd0;
      hist_data_q  <= '0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= accept_d;
      s2_valid_q <= s1_valid_q;
      if (accept_d) begin
        s1_bin_q <= quantise(quotient, sign_x, sign_y, gx_zero);
        s1_mag_q <= mag;
      end
      // Single-cycle read-modify-write, so consecutive hits on one bin never race.
      if (s1_valid_q) begin
        bins_q[s1_bin_q] <= acc_next_d;
      end
      if (in_valid && !in_ready_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_ACCUM: begin
          if (accept_d) begin
            if (count_q == CW'(CELL_N - 1)) begin
              count_q    <= '0;
              state_q    <= ST_FLUSH;
              in_ready_q <= 1'b0;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!s1_valid_q && !s2_valid_q) begin
            state_q      <= ST_DUMP;
            hist_valid_q <= 1'b1;
            hist_bin_q   <= 3'd0;
            hist_data_q  <= bins_q[0];
          end
        end
        ST_DUMP: begin
          if (hist_ready) begin
            bins_q[hist_bin_q] <= '0;
            if (hist_bin_q == 3'd7) begin
              hist_valid_q <= 1'b0;
              hist_bin_q   <= 3'd0;
              hist_data_q  <= '0;
              state_q      <= ST_ACCUM;
              in_ready_q   <= 1'b1;
            end else begin
              hist_bin_q  <= hist_bin_q + 3'd1;
              hist_data_q <= bins_q[hist_bin_q + 3'd1];
            end
          end
        end
        default: begin
          state_q    <= ST_ACCUM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_histogram.sv
// Scoreboard bench for orientation_histogram: a reference model predicts each cell's 8 bin
// totals; a monitor compares every accepted hist beat against the queued expectation.
module tb_orientation_histogram;
  localparam int CELL_N = 4;
  localparam int MAG_W  = 16;
  localparam int ACC_W  = 10;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       quotient;
  logic             sign_x, sign_y, gx_zero;
  logic [MAG_W-1:0] mag;
  logic             in_ready;
  logic             hist_valid;
  logic             hist_ready;
  logic [2:0]       hist_bin;
  logic [ACC_W-1:0] hist_data;
  logic             overrun;

  typedef struct {int bin; int data;} beat_t;
  beat_t exp_q[$];
  int    model_bins[8];
  int    model_cnt;
  bit    exp_overrun;
  int    rdy_mode;
  int    stall2;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  orientation_histogram #(.CELL_N(CELL_N), .MAG_W(MAG_W), .ACC_W(ACC_W),
                          .T1(7), .T2(16), .T3(39)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .quotient(quotient),
    .sign_x(sign_x), .sign_y(sign_y), .gx_zero(gx_zero), .mag(mag),
    .in_ready(in_ready), .hist_valid(hist_valid), .hist_ready(hist_ready),
    .hist_bin(hist_bin), .hist_data(hist_data), .overrun(overrun)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Orientation sector: number of tan boundaries the ratio has crossed, mirrored for mixed signs.
  function automatic int ref_bin(input int q, input bit sx, input bit sy, input bit gz);
    int thr[3] = '{7, 16, 39};
    int sub = 0;
    if (gz) return 4;
    foreach (thr[i]) if (q >= thr[i]) sub++;
    return (sx != sy) ? 7 - sub : sub;
  endfunction

  task automatic model_accept(input int q, input bit sx, input bit sy, input bit gz,
                              input int m, output bit done);
    int b = ref_bin(q, sx, sy, gz);
    model_bins[b] = (model_bins[b] + m > MAXV) ? MAXV : model_bins[b] + m;
    model_cnt++;
    done = 1'b0;
    if (model_cnt == CELL_N) begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back('{bin: i, data: model_bins[i]});
        model_bins[i] = 0;
      end
      model_cnt = 0;
      done = 1'b1;
    end
  endtask

  task automatic send(input int q, input bit sx, input bit sy, input bit gz, input int m);
    bit rdy, done;
    @(negedge clk);
    in_valid = 1'b1; quotient = q[7:0]; sign_x = sx; sign_y = sy; gx_zero = gz; mag = m[15:0];
    rdy = in_ready;
    @(posedge clk);
    if (rdy) begin
      model_accept(q, sx, sy, gz, m, done);
      if (done) begin
        #1 chk("ready_drop_after_cell", in_ready, 0);
      end
    end else begin
      exp_overrun = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic random_cell();
    for (int i = 0; i < CELL_N; i++) begin
      send($urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 400));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
  endtask

  // Descriptor-side backpressure patterns.
  initial begin
    hist_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: hist_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (hist_valid && hist_bin == 3'd2 && stall2 < 3) begin
            hist_ready = 1'b0;
            stall2++;
          end else begin
            hist_ready = 1'b1;
          end
        end
        3: hist_ready = !(hist_valid && hist_bin == 3'd4);
        default: hist_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares each transferred beat and checks stalled beats hold steady.
  initial begin
    bit   stalled = 1'b0;
    int   prev_bin, prev_data;
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stalled) begin
          chk("stall_valid_hold", hist_valid, 1);
          chk("stall_bin_hold", hist_bin, prev_bin);
          chk("stall_data_hold", hist_data, prev_data);
        end
        stalled   = hist_valid && !hist_ready;
        prev_bin  = hist_bin;
        prev_data = hist_data;
        if (hist_valid && hist_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_bin", hist_bin, e.bin);
            chk("beat_data", hist_data, e.data);
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int k;
    reset = 1'b0; in_valid = 1'b0; quotient = 8'd0; sign_x = 1'b0; sign_y = 1'b0;
    gx_zero = 1'b0; mag = '0; rdy_mode = 0; stall2 = 0; exp_overrun = 1'b0; model_cnt = 0;
    foreach (model_bins[i]) model_bins[i] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hist_valid", hist_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_hist_bin", hist_bin, 0);
    chk("reset_hist_data", hist_data, 0);
    reset = 1'b1;

    // One cell all in sector 3.
    repeat (4) send(194, 1'b0, 1'b0, 1'b0, 100);
    wait_ready();

    // Threshold boundaries, mirrored sector and vertical gradient.
    send(6, 1'b0, 1'b0, 1'b0, 1);
    send(7, 1'b0, 1'b0, 1'b0, 2);
    send(15, 1'b0, 1'b0, 1'b0, 4);
    send(16, 1'b0, 1'b0, 1'b0, 8);
    wait_ready();
    send(38, 1'b0, 1'b0, 1'b0, 16);
    send(39, 1'b0, 1'b0, 1'b0, 32);
    send(6, 1'b1, 1'b0, 1'b0, 64);
    send(200, 1'b1, 1'b1, 1'b1, 128);
    wait_ready();

    // Saturation.
    repeat (4) send(20, 1'b0, 1'b1, 1'b0, 300);
    wait_ready();

    // Backpressure on bin 2 plus samples dropped while the cell drains.
    rdy_mode = 2; stall2 = 0;
    random_cell();
    send(100, 1'b0, 1'b0, 1'b0, 77);
    send(3, 1'b1, 1'b0, 1'b0, 55);
    wait_ready();
    chk("overrun_sticky", overrun, exp_overrun);
    chk("overrun_expected_set", exp_overrun, 1);
    random_cell();
    wait_ready();

    rdy_mode = 1;
    repeat (6) begin
      random_cell();
      wait_ready();
    end

    // Reset while bin 4 is on the output.
    rdy_mode = 3;
    random_cell();
    k = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!(hist_valid && hist_bin == 3'd4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("reach_bin4_timeout", 0, 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_dump_valid", hist_valid, 0);
    exp_q.delete();
    foreach (model_bins[i]) model_bins[i] = 0;
    model_cnt = 0;
    exp_overrun = 1'b0;
    reset = 1'b1;
    chk("post_reset_overrun", overrun, 0);
    chk("post_reset_in_ready", in_ready, 1);
    rdy_mode = 0;
    random_cell();
    wait_ready();

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("final_overrun", overrun, exp_overrun);
    chk("final_hist_valid", hist_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
